// File: rtl/seq_pkg.sv
// Shared sequencer definitions for the 4x4 step grid, used by the keypad
// scanner, the sequencer core and the LED matrix driver.
package seq_pkg;

    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 4;
    localparam int NUM_STEPS = 16;

    typedef logic [3:0]  step_idx_t;
    typedef logic [15:0] step_mask_t;
    typedef logic [1:0]  row_idx_t;
    typedef logic [1:0]  col_idx_t;

    // Grid position to step number; matches the button numbering (4*row + col).
    function automatic step_idx_t step_index(input row_idx_t row, input col_idx_t col);
        return {row, col};
    endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Row-slot timer for multiplexed 4x4 matrices: walks four row slots of
// ROW_PERIOD cycles each, the first BLANK_CYCLES of every slot being dead time.
module matrix_scan_timer
    import seq_pkg::*;
#(
    parameter int ROW_PERIOD   = 3000,
    parameter int BLANK_CYCLES = 12
) (
    input  logic     clk,
    input  logic     rst,
    output row_idx_t row_idx,
    output logic     active,
    output logic     frame_start,
    output logic     frame_end,
    output logic     blank_last
);

    localparam int CNT_W = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ROW_PERIOD - 1);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Slot counter; the row index advances when a slot completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            row_idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

    assign active      = (cnt >= BLANK_END);
    assign frame_start = (row_idx == 2'd0) && (cnt == '0);
    assign frame_end   = (row_idx == 2'd3) && (cnt == CNT_LAST);
    assign blank_last  = (cnt == BLANK_LAST);

endmodule

// File: rtl/led_matrix_driver.sv
// 4x4 step LED driver: one active-low row at a time, enabled steps at a PWM
// dim level, the playhead step at full brightness, inputs sampled once per frame.
module led_matrix_driver
    import seq_pkg::*;
#(
    parameter int ROW_PERIOD   = 3000,
    parameter int BLANK_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  step_mask_t pattern,
    input  step_idx_t  playhead,
    input  logic       playhead_valid,
    input  logic [3:0] dim_level,
    output logic [3:0] row_n,
    output logic [3:0] col,
    output logic       frame_tick
);

    row_idx_t   row_idx;
    logic       active;
    logic       frame_start;
    logic       frame_end;
    logic       blank_last;

    step_mask_t shadow_pattern;
    step_idx_t  shadow_playhead;
    logic       shadow_valid;
    logic [3:0] shadow_dim;
    logic [3:0] pwm_cnt;

    logic [3:0] row_n_next;
    logic [3:0] col_next;

    matrix_scan_timer #(
        .ROW_PERIOD   (ROW_PERIOD),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .row_idx     (row_idx),
        .active      (active),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .blank_last  (blank_last)
    );

    // Frame snapshot so a pattern edit never tears a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_pattern  <= 16'h0000;
            shadow_playhead <= 4'd0;
            shadow_valid    <= 1'b0;
            shadow_dim      <= 4'd0;
        end else if (frame_start) begin
            shadow_pattern  <= pattern;
            shadow_playhead <= playhead;
            shadow_valid    <= playhead_valid;
            shadow_dim      <= dim_level;
        end
    end

    // PWM phase restarts on the last blank cycle so every ACTIVE phase starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 4'd0;
        end else if (blank_last) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    // Row select and per-column brightness decision for the current cycle.
    always_comb begin
        row_n_next = 4'hF;
        col_next   = 4'h0;
        if (active) begin
            row_n_next = ~(4'b0001 << row_idx);
            for (int c = 0; c < NUM_COLS; c++) begin
                col_next[c] = (shadow_valid && (shadow_playhead == step_index(row_idx, col_idx_t'(c))))
                            || (shadow_pattern[step_index(row_idx, col_idx_t'(c))] && (pwm_cnt < shadow_dim));
            end
        end else begin
            row_n_next = 4'hF;
            col_next   = 4'h0;
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_n      <= 4'hF;
            col        <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            row_n      <= row_n_next;
            col        <= col_next;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_led_matrix_driver.sv
// Bench for led_matrix_driver: directed and random input sequences checked
// cycle by cycle against a frame-timeline model of the LED scan.
module tb_led_matrix_driver;

    localparam int RP    = 20;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RP;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pattern;
    logic [3:0]  playhead;
    logic        playhead_valid;
    logic [3:0]  dim_level;
    logic [3:0]  row_n;
    logic [3:0]  col;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: non-reset edges since the last reset, and the frame snapshot in force.
    int          n       = 0;
    int          last_ft = -1;
    logic [15:0] m_pat   = 16'h0000;
    logic [3:0]  m_ph    = 4'd0;
    logic        m_pv    = 1'b0;
    logic [3:0]  m_dim   = 4'd0;

    led_matrix_driver #(.ROW_PERIOD(RP), .BLANK_CYCLES(BC)) dut (
        .clk            (clk),
        .rst            (rst),
        .pattern        (pattern),
        .playhead       (playhead),
        .playhead_valid (playhead_valid),
        .dim_level      (dim_level),
        .row_n          (row_n),
        .col            (col),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic rand_inputs();
        pattern        = 16'($urandom);
        playhead       = 4'($urandom);
        playhead_valid = 1'($urandom);
        dim_level      = 4'($urandom);
    endtask

    task automatic tick();
        logic [3:0] e_row;
        logic [3:0] e_col;
        logic       e_ft;
        int pos, r, c, idx;
        e_row = 4'hF;
        e_col = 4'h0;
        e_ft  = 1'b0;
        pos   = n % FRAME;
        r     = pos / RP;
        c     = pos % RP;
        if (!rst) begin
            e_ft = (pos == FRAME - 1);
            if (c >= BC) begin
                e_row[r] = 1'b0;
                for (int cc = 0; cc < 4; cc++) begin
                    idx = 4 * r + cc;
                    e_col[cc] = (m_pv && int'(m_ph) == idx)
                             || (m_pat[idx] && (((c - BC) % 16) < int'(m_dim)));
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        assert (row_n === e_row) else begin
            errors++;
            $error("FAIL row_n: observed %h expected %h (cycle %0d)", row_n, e_row, cyc);
        end
        checks++;
        assert (col === e_col) else begin
            errors++;
            $error("FAIL col: observed %h expected %h (cycle %0d)", col, e_col, cyc);
        end
        checks++;
        assert (frame_tick === e_ft) else begin
            errors++;
            $error("FAIL frame_tick: observed %b expected %b (cycle %0d)", frame_tick, e_ft, cyc);
        end
        if (frame_tick === 1'b1) begin
            if (last_ft >= 0) begin
                checks++;
                assert (cyc - last_ft == FRAME) else begin
                    errors++;
                    $error("FAIL tick_period: observed %0d expected %0d", cyc - last_ft, FRAME);
                end
            end
            last_ft = cyc;
        end
        if (rst) begin
            n       = 0;
            last_ft = -1;
            m_pat   = 16'h0000;
            m_ph    = 4'd0;
            m_pv    = 1'b0;
            m_dim   = 4'd0;
        end else begin
            if (pos == 0) begin
                m_pat = pattern;
                m_ph  = playhead;
                m_pv  = playhead_valid;
                m_dim = dim_level;
            end
            n++;
        end
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < FRAME && (n % FRAME) != target; k++) tick();
    endtask

    initial begin
        rst = 1'b1;
        rand_inputs();
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            tick();
        end

        // Single enabled LED at dim 15, then dim 0.
        pattern        = 16'h0001;
        dim_level      = 4'd15;
        playhead_valid = 1'b0;
        playhead       = 4'($urandom);
        rst            = 1'b0;
        run(2 * FRAME);
        dim_level = 4'd0;
        run(2 * FRAME);

        // Playhead only.
        pattern        = 16'h0000;
        playhead       = 4'd5;
        playhead_valid = 1'b1;
        dim_level      = 4'($urandom);
        run(2 * FRAME);

        // Random inputs changing at arbitrary points in the frame.
        for (int k = 0; k < 10 * FRAME; k++) begin
            if ($urandom_range(0, 19) == 0) rand_inputs();
            tick();
        end

        // Pattern change mid-frame must wait for the next snapshot.
        pattern        = 16'h0000;
        dim_level      = 4'd8;
        playhead_valid = 1'b0;
        run(FRAME);
        run_to(RP + 10);
        pattern = 16'hFFFF;
        run(3 * FRAME);

        // Single-cycle reset in the middle of row 2.
        run_to(2 * RP + 7);
        rst = 1'b1;
        rand_inputs();
        tick();
        rst = 1'b0;
        rand_inputs();
        run(3 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
